iram_arbiter: RTL and testbench

Two-port arbiter and access sequencer for the 256-byte internal data RAM. It shares the single RAM port between the CPU core (port A) and the debug/loader interface (port B). Each requester gets a req/ack handshake. The block converts bit-addressed accesses into byte accesses: a single read for bit reads, and a read-modify-write sequence for bit writes. It sits between the core/debug logic and the RAM macro, and it is the only master of the RAM control pins.

---
 rtl/i8051_pkg.sv | 27 ++
 rtl/bit_addr_map.sv | 20 ++
 rtl/iram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_iram_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i8051_pkg.sv
// Shared types and constants for the i8051 internal-RAM datapath.
// Holds the arbiter state encoding and the bit-addressable region bases.
package i8051_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WR,
        ST_RMW_RD,
        ST_RMW_WR,
        ST_DONE
    } iram_state_t;

    localparam logic [7:0] BIT_BASE_LO = 8'h20;
    localparam logic [7:0] SFR_BASE    = 8'h80;

    // Replace one bit of a byte, leaving the other seven untouched.
    function automatic logic [7:0] set_bit(input logic [7:0] i_byte,
                                           input logic [2:0] i_idx,
                                           input logic       i_val);
        logic [7:0] w_res;
        w_res        = i_byte;
        w_res[i_idx] = i_val;
        return w_res;
    endfunction

endpackage

// File: rtl/bit_addr_map.sv
// Maps an 8-bit bit address onto its containing byte address and bit index.
// Low bit space lives at 0x20-0x2F; high bit space addresses 8-byte-aligned SFRs.
module bit_addr_map
    import i8051_pkg::*;
(
    input  logic [7:0] i_bit_addr,
    output logic [7:0] o_byte_addr,
    output logic [2:0] o_bit_idx
);

    always_comb begin
        if (i_bit_addr < SFR_BASE) begin
            o_byte_addr = BIT_BASE_LO + {4'h0, i_bit_addr[6:3]};
        end else begin
            o_byte_addr = {i_bit_addr[7:3], 3'b000};
        end
        o_bit_idx = i_bit_addr[2:0];
    end

endmodule

// File: rtl/iram_arbiter.sv
// Two-port arbiter and access sequencer for the 256-byte internal data RAM.
// Serialises core (A) and debug (B) accesses; bit writes become read-modify-write.
module iram_arbiter
    import i8051_pkg::*;
#(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_req,
    input  logic       a_wr,
    input  logic       a_bit,
    input  logic [7:0] a_addr,
    input  logic [7:0] a_wdata,
    input  logic       a_wbit,
    output logic       a_ack,
    input  logic       b_req,
    input  logic       b_wr,
    input  logic       b_bit,
    input  logic [7:0] b_addr,
    input  logic [7:0] b_wdata,
    input  logic       b_wbit,
    output logic       b_ack,
    output logic [7:0] rdata,
    output logic       rbit,
    output logic       ram_rd,
    output logic       ram_wr,
    output logic [7:0] ram_addr,
    output logic [7:0] ram_wdata,
    input  logic [7:0] ram_rdata
);

    iram_state_t r_state;
    iram_state_t w_next;

    logic       r_port;     // granted port: 0 = A, 1 = B
    logic       r_last;     // last granted port, drives the round-robin tie-break
    logic       r_wr;
    logic       r_bit;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_wbit;
    logic [7:0] r_rdata;
    logic       r_rbit;

    logic       w_grant;
    logic       w_grant_b;
    logic       w_sel_wr;
    logic       w_sel_bit;
    logic [7:0] w_sel_addr;
    logic [7:0] w_sel_wdata;
    logic       w_sel_wbit;
    logic [7:0] w_map_addr;
    logic [2:0] w_idx;
    logic [7:0] w_ram_addr;

    bit_addr_map u_map (
        .i_bit_addr  (r_addr),
        .o_byte_addr (w_map_addr),
        .o_bit_idx   (w_idx)
    );

    assign w_grant     = a_req | b_req;
    assign w_grant_b   = b_req & (~a_req | (RR_EN & ~r_last));
    assign w_sel_wr    = w_grant_b ? b_wr    : a_wr;
    assign w_sel_bit   = w_grant_b ? b_bit   : a_bit;
    assign w_sel_addr  = w_grant_b ? b_addr  : a_addr;
    assign w_sel_wdata = w_grant_b ? b_wdata : a_wdata;
    assign w_sel_wbit  = w_grant_b ? b_wbit  : a_wbit;
    assign w_ram_addr  = r_bit ? w_map_addr : r_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        ram_rd    = 1'b0;
        ram_wr    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        rdata     = r_rdata;
        rbit      = r_rbit;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    if (!w_sel_wr)      w_next = ST_RD;
                    else if (w_sel_bit) w_next = ST_RMW_RD;
                    else                w_next = ST_WR;
                end
            end
            ST_RD: begin
                ram_rd   = 1'b1;
                ram_addr = w_ram_addr;
                w_next   = ST_DONE;
            end
            ST_WR: begin
                ram_wr    = 1'b1;
                ram_addr  = w_ram_addr;
                ram_wdata = r_wdata;
                w_next    = ST_DONE;
            end
            ST_RMW_RD: begin
                ram_rd   = 1'b1;
                ram_addr = w_ram_addr;
                w_next   = ST_RMW_WR;
            end
            ST_RMW_WR: begin
                ram_wr    = 1'b1;
                ram_addr  = w_ram_addr;
                ram_wdata = set_bit(ram_rdata, w_idx, r_wbit);
                w_next    = ST_DONE;
            end
            ST_DONE: begin
                a_ack  = ~r_port;
                b_ack  = r_port;
                w_next = ST_IDLE;
                // Read data is presented straight from the RAM in the ack cycle, then held.
                if (!r_wr) begin
                    rdata = ram_rdata;
                    rbit  = ram_rdata[w_idx];
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_port  <= 1'b0;
            r_last  <= 1'b1;
            r_wr    <= 1'b0;
            r_bit   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wbit  <= 1'b0;
            r_rdata <= '0;
            r_rbit  <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && w_grant) begin
                r_port  <= w_grant_b;
                r_last  <= w_grant_b;
                r_wr    <= w_sel_wr;
                r_bit   <= w_sel_bit;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_wbit  <= w_sel_wbit;
            end
            if (r_state == ST_DONE && !r_wr) begin
                r_rdata <= ram_rdata;
                r_rbit  <= ram_rdata[w_idx];
            end
        end
    end

endmodule

// File: tb/tb_iram_arbiter.sv
// Self-checking bench for iram_arbiter: table-driven accesses against a RAM model,
// an ack scoreboard, and hand-written arbitration / reset / contention sequences.
module tb_iram_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_wr, a_bit, a_wbit, a_ack;
    logic [7:0] a_addr, a_wdata;
    logic       b_req, b_wr, b_bit, b_wbit, b_ack;
    logic [7:0] b_addr, b_wdata;
    logic [7:0] rdata;
    logic       rbit;
    logic       ram_rd, ram_wr;
    logic [7:0] ram_addr, ram_wdata;
    logic [7:0] ram_rdata = 8'h00;

    logic       f_a_req, f_b_req, f_z1;
    logic [7:0] f_z8;
    logic       f_a_ack, f_b_ack, f_rbit, f_ram_rd, f_ram_wr;
    logic [7:0] f_rdata, f_ram_addr, f_ram_wdata;

    logic [7:0] mem [0:255];
    int         n_ramwr = 0;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       port;
        logic       wr;
        logic       bt;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic       wbit;
        logic [7:0] exp_ram_addr;
        logic [7:0] exp_wdata;
        logic [7:0] exp_rdata;
        logic       exp_rbit;
    } vec_t;

    typedef struct {
        logic       port;
        logic [7:0] rdata;
        logic       chk_bit;
        logic       rbit;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] last_rd = 8'h00;
    vec_t       vt [18];

    always #5 clk = ~clk;

    iram_arbiter #(.RR_EN(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_bit(a_bit), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_wbit(a_wbit), .a_ack(a_ack),
        .b_req(b_req), .b_wr(b_wr), .b_bit(b_bit), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_wbit(b_wbit), .b_ack(b_ack),
        .rdata(rdata), .rbit(rbit),
        .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    iram_arbiter #(.RR_EN(1'b0)) u_dut_fix (
        .clk(clk), .rst_n(rst_n),
        .a_req(f_a_req), .a_wr(f_z1), .a_bit(f_z1), .a_addr(f_z8),
        .a_wdata(f_z8), .a_wbit(f_z1), .a_ack(f_a_ack),
        .b_req(f_b_req), .b_wr(f_z1), .b_bit(f_z1), .b_addr(f_z8),
        .b_wdata(f_z8), .b_wbit(f_z1), .b_ack(f_b_ack),
        .rdata(f_rdata), .rbit(f_rbit),
        .ram_rd(f_ram_rd), .ram_wr(f_ram_wr), .ram_addr(f_ram_addr),
        .ram_wdata(f_ram_wdata), .ram_rdata(f_z8)
    );

    // RAM macro model: read data appears the cycle after ram_rd.
    always @(posedge clk) begin
        if (ram_wr) begin
            mem[ram_addr] <= ram_wdata;
            n_ramwr       <= n_ramwr + 1;
        end
        if (ram_rd) ram_rdata <= mem[ram_addr];
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every ack pops the oldest expected completion.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (ram_rd && ram_wr) chk("strobe exclusive", 1, 0);
        if (a_ack && b_ack) chk("ack exclusive", 1, 0);
        if (a_ack || b_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected ack", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("ack port", b_ack, e.port);
                chk("ack rdata", rdata, e.rdata);
                if (e.chk_bit) chk("ack rbit", rbit, e.rbit);
            end
        end
    end

    task automatic drive(input logic port, input logic req, input logic wr, input logic bt,
                         input logic [7:0] addr, input logic [7:0] wd, input logic wb);
        if (!port) begin
            a_req = req; a_wr = wr; a_bit = bt; a_addr = addr; a_wdata = wd; a_wbit = wb;
        end else begin
            b_req = req; b_wr = wr; b_bit = bt; b_addr = addr; b_wdata = wd; b_wbit = wb;
        end
    endtask

    task automatic push(input logic port, input logic [7:0] rd, input logic cb, input logic rb);
        exp_t e;
        e.port = port; e.rdata = rd; e.chk_bit = cb; e.rbit = rb;
        sb.push_back(e);
    endtask

    task automatic access(input vec_t v);
        int   cyc;
        logic ack;
        logic rmw;
        rmw = v.wr & v.bt;
        if (v.wr) begin
            push(v.port, last_rd, 1'b0, 1'b0);
        end else begin
            push(v.port, v.exp_rdata, v.bt, v.exp_rbit);
            last_rd = v.exp_rdata;
        end
        drive(v.port, 1'b1, v.wr, v.bt, v.addr, v.wdata, v.wbit);
        cyc = 0;
        do begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1) begin
                chk("c1 ram_rd", ram_rd, !v.wr || v.bt);
                chk("c1 ram_wr", ram_wr, v.wr && !v.bt);
                chk("c1 ram_addr", ram_addr, v.exp_ram_addr);
                if (v.wr && !v.bt) chk("c1 ram_wdata", ram_wdata, v.exp_wdata);
            end
            if (cyc == 2 && rmw) begin
                chk("c2 ram_rd", ram_rd, 0);
                chk("c2 ram_wr", ram_wr, 1);
                chk("c2 ram_addr", ram_addr, v.exp_ram_addr);
                chk("c2 ram_wdata", ram_wdata, v.exp_wdata);
            end
            ack = v.port ? b_ack : a_ack;
        end while (!ack && cyc < 20);
        chk("ack latency", cyc, rmw ? 3 : 2);
        drive(v.port, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int n;
        int na;
        int nb;
        int wr0;
        vec_t h;

        //          port wr bt addr   wdata  wb  ramadr wdata  rdata  rbit
        vt[0]  = '{1'b0, 1, 0, 8'h30, 8'h5A, 0, 8'h30, 8'h5A, 8'h00, 0};
        vt[1]  = '{1'b0, 0, 0, 8'h30, 8'h00, 0, 8'h30, 8'h00, 8'h5A, 0};
        vt[2]  = '{1'b1, 1, 0, 8'h21, 8'h00, 0, 8'h21, 8'h00, 8'h00, 0};
        vt[3]  = '{1'b0, 1, 1, 8'h0B, 8'h00, 1, 8'h21, 8'h08, 8'h00, 0};
        vt[4]  = '{1'b1, 0, 0, 8'h21, 8'h00, 0, 8'h21, 8'h00, 8'h08, 0};
        vt[5]  = '{1'b1, 1, 0, 8'hE0, 8'h80, 0, 8'hE0, 8'h80, 8'h00, 0};
        vt[6]  = '{1'b0, 0, 1, 8'hE7, 8'h00, 0, 8'hE0, 8'h00, 8'h80, 1};
        vt[7]  = '{1'b1, 0, 1, 8'hE6, 8'h00, 0, 8'hE0, 8'h00, 8'h80, 0};
        vt[8]  = '{1'b0, 1, 0, 8'h2F, 8'h7E, 0, 8'h2F, 8'h7E, 8'h00, 0};
        vt[9]  = '{1'b1, 1, 1, 8'h78, 8'h00, 1, 8'h2F, 8'h7F, 8'h00, 0};
        vt[10] = '{1'b0, 1, 1, 8'h7E, 8'h00, 0, 8'h2F, 8'h3F, 8'h00, 0};
        vt[11] = '{1'b1, 0, 1, 8'h7E, 8'h00, 0, 8'h2F, 8'h00, 8'h3F, 0};
        vt[12] = '{1'b0, 1, 0, 8'h80, 8'hF0, 0, 8'h80, 8'hF0, 8'h00, 0};
        vt[13] = '{1'b1, 1, 1, 8'h83, 8'h00, 1, 8'h80, 8'hF8, 8'h00, 0};
        vt[14] = '{1'b0, 0, 0, 8'h80, 8'h00, 0, 8'h80, 8'h00, 8'hF8, 0};
        vt[15] = '{1'b1, 1, 0, 8'h20, 8'hFF, 0, 8'h20, 8'hFF, 8'h00, 0};
        vt[16] = '{1'b0, 1, 1, 8'h00, 8'h00, 0, 8'h20, 8'hFE, 8'h00, 0};
        vt[17] = '{1'b1, 0, 1, 8'h07, 8'h00, 0, 8'h20, 8'h00, 8'hFE, 1};

        f_z1 = 1'b0; f_z8 = 8'h00; f_a_req = 1'b0; f_b_req = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_ack", a_ack, 0);
        chk("rst b_ack", b_ack, 0);
        chk("rst ram_rd", ram_rd, 0);
        chk("rst ram_wr", ram_wr, 0);
        chk("rst ram_addr", ram_addr, 0);
        chk("rst ram_wdata", ram_wdata, 0);
        chk("rst rdata", rdata, 0);
        chk("rst rbit", rbit, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) access(vt[i]);

        // B arrives while A is in the middle of a bit RMW on byte 0x21 (0x08 -> 0x09).
        push(1'b0, last_rd, 1'b0, 1'b0);
        push(1'b1, 8'h09, 1'b0, 1'b0);
        last_rd = 8'h09;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h08, 8'h00, 1'b1);
        @(posedge clk); #1;
        chk("mid-rmw ram_rd", ram_rd, 1);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
        cyc = 0;
        do begin @(posedge clk); #1; cyc++; end while (!a_ack && cyc < 10);
        chk("mid-rmw a latency", cyc, 2);
        chk("mid-rmw b no ack", b_ack, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (ram_rd) chk("b after rmw ram_addr", ram_addr, 8'h21);
        end while (!b_ack && cyc < 10);
        chk("b after rmw latency", cyc, 3);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;

        // Reset pulsed during RMW_RD must leave byte 0x2F untouched.
        h = '{1'b1, 1, 0, 8'h2F, 8'hFF, 0, 8'h2F, 8'hFF, 8'h00, 0};
        access(h);
        wr0 = n_ramwr;
        drive(1'b0, 1'b1, 1'b1, 1'b1, 8'h7B, 8'h00, 1'b0);
        @(posedge clk); #1;
        chk("abort ram_rd before", ram_rd, 1);
        chk("abort ram_addr before", ram_addr, 8'h2F);
        #2 rst_n = 1'b0;
        #1;
        chk("abort ram_rd", ram_rd, 0);
        chk("abort ram_wr", ram_wr, 0);
        chk("abort a_ack", a_ack, 0);
        chk("abort ram_addr", ram_addr, 0);
        chk("abort ram_wdata", ram_wdata, 0);
        chk("abort rdata", rdata, 0);
        chk("abort rbit", rbit, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        last_rd = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("abort no ram_wr", n_ramwr, wr0);
        h = '{1'b1, 0, 0, 8'h2F, 8'h00, 0, 8'h2F, 8'h00, 8'hFF, 0};
        access(h);

        // Continuous tie with round-robin: A,B,A,B,A,B starting with A.
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) push(1'b0, 8'h5A, 1'b0, 1'b0);
            else            push(1'b1, 8'h09, 1'b0, 1'b0);
        end
        last_rd = 8'h09;
        drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h30, 8'h00, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h21, 8'h00, 1'b0);
        n = 0; cyc = 0;
        while (n < 6 && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (a_ack || b_ack) n++;
        end
        chk("rr ack count", n, 6);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        @(posedge clk); #1;

        // Fixed priority instance: A held high starves B.
        f_a_req = 1'b1; f_b_req = 1'b1;
        na = 0; nb = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (f_a_ack) na++;
            if (f_b_ack) nb++;
        end
        f_a_req = 1'b0; f_b_req = 1'b0;
        chk("fixed a acks", na, 5);
        chk("fixed b acks", nb, 0);
        repeat (4) @(posedge clk);
        #1;

        chk("scoreboard drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
